key_matrix_scanner: RTL and testbench

//  Reads a scanned, multiplexed button matrix: drives one row low at a time, samples the active-low

---
 rtl/key_matrix_scanner_if.sv | 23 ++
 rtl/key_matrix_scanner.sv | 139 +++++++++++++
 tb/tb_key_matrix_scanner.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/key_matrix_scanner_if.sv
// Scanner-side bundle: column returns in, row strobes plus per-key debounced level/edge flags out.
interface key_matrix_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  logic                 scan_en;
  logic [COLS-1:0]      col_sense;
  logic [ROWS-1:0]      row_drive;
  logic [ROWS*COLS-1:0] key_state;
  logic [ROWS*COLS-1:0] key_press;
  logic [ROWS*COLS-1:0] key_release;
  logic                 scan_done;

  modport master (
    input  scan_en, col_sense,
    output row_drive, key_state, key_press, key_release, scan_done
  );

  modport slave (
    output scan_en, col_sense,
    input  row_drive, key_state, key_press, key_release, scan_done
  );
endinterface

// File: rtl/key_matrix_scanner.sv
// Row-strobed key matrix scanner with 2-flop column sync and per-key sample-count debounce.
// Row period SETTLE_CYCLES+1 clocks; key_state/press/release update the cycle after a row's sample.
module key_matrix_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYCLES  = 3,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  key_matrix_scanner_if.master bus
);
  localparam int NKEYS = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW    = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            sample_en;

  logic [COLS-1:0] sync1_q, sync2_q;
  logic [COLS-1:0] closed;

  logic [NKEYS-1:0] key_state_q, key_press_q, key_release_q;
  logic [NKEYS-1:0] flip;

  // Column returns are asynchronous and active-low; sync flops idle at "open".
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.col_sense;
      sync2_q <= sync1_q;
    end
  end

  assign closed = ~sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    sample_en = 1'b0;
    case (state_q)
      IDLE: begin
        row_d = '0;
        cnt_d = '0;
        if (bus.scan_en) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        sample_en = 1'b1;
        cnt_d     = '0;
        row_d     = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        // scan_en is only honoured at row boundaries; a stop always rewinds to row 0.
        if (bus.scan_en) begin
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
          row_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.row_drive = (state_q == IDLE) ? '1 : ~(ROWS'(1) << row_q);
  assign bus.scan_done = (state_q == SAMPLE) && (row_q == RW'(ROWS - 1));

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    localparam int R = i / COLS;
    localparam int C = i % COLS;

    logic [CW-1:0] db_cnt_q;
    logic          hit;
    logic          differ;

    assign hit     = sample_en && (row_q == RW'(R));
    assign differ  = closed[C] != key_state_q[i];
    assign flip[i] = hit && differ && (db_cnt_q == CW'(DEBOUNCE_SCANS - 1));

    always_ff @(posedge clk) begin
      if (reset) begin
        db_cnt_q <= '0;
      end else if (hit) begin
        if (!differ || flip[i]) db_cnt_q <= '0;
        else                    db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_state_q   <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
    end else begin
      key_state_q   <= key_state_q ^ flip;
      key_press_q   <= flip & ~key_state_q;
      key_release_q <= flip & key_state_q;
    end
  end

  assign bus.key_state   = key_state_q;
  assign bus.key_press   = key_press_q;
  assign bus.key_release = key_release_q;
endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench: a combinational 4x4 switch model answers the row strobes; hand-computed expectations.
module tb_key_matrix_scanner;
  logic clk;
  logic reset;
  logic [15:0] pressed;
  logic [3:0]  cs;

  int n_cmp;
  int n_bad;
  int ph;
  int press_cnt;
  int rel_cnt;

  key_matrix_scanner_if #(.ROWS(4), .COLS(4)) kif ();

  key_matrix_scanner #(
    .ROWS(4), .COLS(4), .SETTLE_CYCLES(3), .DEBOUNCE_SCANS(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A closed switch pulls its column low only while its row is strobed.
  always_comb begin
    cs = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.row_drive[r] && pressed[r*4 + c]) cs[c] = 1'b0;
  end
  assign kif.col_sense = cs;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs n clocks of free scanning, checking strobe pattern and frame pulse against phase ph.
  task automatic run_ticks(input int n);
    logic [3:0] exp_row;
    for (int j = 0; j < n; j++) begin
      tick();
      exp_row = 4'b0001 << (ph / 4);
      exp_row = ~exp_row;
      chk("row_drive", 32'(kif.row_drive), 32'(exp_row));
      chk("scan_done", 32'(kif.scan_done), 32'(ph == 15));
      press_cnt += $countones(kif.key_press);
      rel_cnt   += $countones(kif.key_release);
      ph = (ph + 1) % 16;
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; ph = 0; press_cnt = 0; rel_cnt = 0;
    pressed = 16'h0;
    kif.scan_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_row_drive", 32'(kif.row_drive), 32'hF);
    chk("rst_key_state", 32'(kif.key_state), 32'h0);
    chk("rst_key_press", 32'(kif.key_press), 32'h0);
    chk("rst_key_release", 32'(kif.key_release), 32'h0);
    chk("rst_scan_done", 32'(kif.scan_done), 32'h0);
    tick();
    chk("idle_row_drive", 32'(kif.row_drive), 32'hF);

    // Open matrix: two clean frames.
    kif.scan_en = 1'b1;
    run_ticks(32);
    chk("open_key_state", 32'(kif.key_state), 32'h0);
    chk("open_press_cnt", 32'(press_cnt), 32'd0);

    // Key 6 (row 1, col 2) held for three frames.
    pressed = 16'h0040;
    press_cnt = 0; rel_cnt = 0;
    run_ticks(32);
    chk("k6_two_frames", 32'(kif.key_state), 32'h0);
    chk("k6_no_early_press", 32'(press_cnt), 32'd0);
    run_ticks(8);
    chk("k6_at_sample", 32'(kif.key_state), 32'h0);
    run_ticks(1);
    chk("k6_rise_state", 32'(kif.key_state), 32'h0040);
    chk("k6_rise_press", 32'(kif.key_press), 32'h0040);
    run_ticks(1);
    chk("k6_press_one_cycle", 32'(kif.key_press), 32'h0);
    run_ticks(6);
    chk("k6_press_cnt", 32'(press_cnt), 32'd1);
    chk("k6_no_release", 32'(rel_cnt), 32'd0);

    // Key 6 released for three frames.
    pressed = 16'h0;
    run_ticks(32);
    chk("k6_rel_held", 32'(kif.key_state), 32'h0040);
    chk("k6_rel_early", 32'(rel_cnt), 32'd0);
    run_ticks(9);
    chk("k6_fall_state", 32'(kif.key_state), 32'h0);
    chk("k6_fall_release", 32'(kif.key_release), 32'h0040);
    run_ticks(7);
    chk("k6_release_cnt", 32'(rel_cnt), 32'd1);
    chk("k6_press_cnt_after", 32'(press_cnt), 32'd1);

    // Bounce: closed two frames, then open again.
    press_cnt = 0; rel_cnt = 0;
    pressed = 16'h0040;
    run_ticks(32);
    pressed = 16'h0;
    run_ticks(32);
    chk("bounce_state", 32'(kif.key_state), 32'h0);
    chk("bounce_press", 32'(press_cnt), 32'd0);
    chk("bounce_release", 32'(rel_cnt), 32'd0);

    // Keys 0, 5, 6, 15 together; 5 and 6 share a row.
    press_cnt = 0; rel_cnt = 0;
    pressed = 16'h8061;
    run_ticks(32);
    chk("multi_two_frames", 32'(kif.key_state), 32'h0);
    run_ticks(5);
    chk("multi_row0_state", 32'(kif.key_state), 32'h0001);
    chk("multi_row0_press", 32'(kif.key_press), 32'h0001);
    run_ticks(4);
    chk("multi_row1_state", 32'(kif.key_state), 32'h0061);
    chk("multi_row1_press", 32'(kif.key_press), 32'h0060);
    run_ticks(8);
    chk("multi_row3_state", 32'(kif.key_state), 32'h8061);
    chk("multi_row3_press", 32'(kif.key_press), 32'h8000);
    run_ticks(15);
    chk("multi_press_cnt", 32'(press_cnt), 32'd4);

    // Key 10 (row 2) debounces on the row sampled after scan_en drops.
    pressed = 16'h8461;
    run_ticks(32);
    chk("k10_two_frames", 32'(kif.key_state), 32'h8061);
    run_ticks(10);
    kif.scan_en = 1'b0;
    tick();
    chk("stop_settle_row", 32'(kif.row_drive), 32'hB);
    tick();
    chk("stop_sample_row", 32'(kif.row_drive), 32'hB);
    chk("stop_no_done", 32'(kif.scan_done), 32'h0);
    tick();
    chk("stop_idle_row", 32'(kif.row_drive), 32'hF);
    chk("stop_k10_state", 32'(kif.key_state), 32'h8461);
    chk("stop_k10_press", 32'(kif.key_press), 32'h0400);

    // Idle holds key_state even though every switch opens.
    pressed = 16'h0;
    for (int j = 0; j < 20; j++) tick();
    chk("idle_hold_row", 32'(kif.row_drive), 32'hF);
    chk("idle_hold_state", 32'(kif.key_state), 32'h8461);
    chk("idle_no_release", 32'(kif.key_release), 32'h0);

    // Re-enable restarts at row 0.
    kif.scan_en = 1'b1;
    ph = 0;
    run_ticks(4);
    chk("restart_state", 32'(kif.key_state), 32'h8461);

    // Reset mid-scan clears everything and returns to idle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_row", 32'(kif.row_drive), 32'hF);
    chk("mid_rst_state", 32'(kif.key_state), 32'h0);
    chk("mid_rst_release", 32'(kif.key_release), 32'h0);
    chk("mid_rst_done", 32'(kif.scan_done), 32'h0);
    ph = 0;
    press_cnt = 0; rel_cnt = 0;
    run_ticks(16);
    chk("post_rst_state", 32'(kif.key_state), 32'h0);
    chk("post_rst_edges", 32'(press_cnt + rel_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
